led_bcd_feeder: RTL and testbench
=================================

Name: led_bcd_feeder

Overview:
- Sits between the CPU's memory-mapped LED write port and the 4-digit seven-segment scanner.
- Accepts a 16-bit value written by the CPU. Produces four 4-bit digit nibbles plus a one-cycle load strobe that the scanner uses to latch the digits.
- Two modes:
  - Hex mode: passes the nibbles straight through.
  - Decimal mode: converts the value to 4 BCD digits with a sequential shift-add-3 (double dabble) engine, one bit per cycle.
- Includes a one-deep pending buffer so that CPU writes arriving during a conversion are not lost.

Parameters:
- CONV_BITS, 14, number of shift iterations in decimal mode. The value is saturated to 14 bits, max 9999.
- DEC_MAX, 9999, largest value representable in decimal mode.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  CPU write strobe, one cycle per write.
- wr_data  input  16  value to display.
- dec_mode  input  1  sampled together with wr_en. 1 = decimal, 0 = hex.
- busy  output  1  decimal conversion in progress.
- ovf  output  1  the last published decimal value exceeded DEC_MAX.
- l0  output  4  rightmost digit (ones / nibble 0).
- l1  output  4  digit 1.
- l2  output  4  digit 2.
- l3  output  4  leftmost digit.
- led_ctrl  output  1  one-cycle strobe. The digit outputs are valid and stable in this cycle and are held until the next strobe.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; l0..l3=0; led_ctrl=0; busy=0; ovf=0; pending buffer empty; shift register and counter cleared.
- All outputs are registered.
- States: IDLE, CONV.

IDLE, on a clock edge E0:
- If wr_en=1 and dec_mode=0 (hex):
  - {l3,l2,l1,l0} <= wr_data; ovf <= 0; led_ctrl high in the cycle after E0 (latency 1).
  - State stays IDLE.
- If wr_en=1 and dec_mode=1 (decimal):
  - Operand = min(wr_data, DEC_MAX); ovf_next = (wr_data > DEC_MAX).
  - Load the operand into the binary shift field, clear the BCD field, counter=0, go to CONV.
- If wr_en=0 and the pending buffer is valid: start the pending request exactly as above, then clear the pending buffer.
- If wr_en=1 and the pending buffer is valid at the same edge: the new write wins and the pending buffer is discarded.

CONV:
- busy=1 for every cycle the state is CONV.
- Edges E1..E14: for each BCD nibble >=5 add 3, then shift the combined {bcd,bin} register left by 1. The counter increments each edge.
- Edge E15: publish the BCD nibbles to l3..l0, update ovf, pulse led_ctrl, return to IDLE.
- Decimal latency: led_ctrl is high in the cycle after E15, i.e. 15 cycles after the edge that sampled wr_en.

Pending buffer:
- Any wr_en sampled while busy=1 (including at E15) stores {dec_mode, wr_data} in the pending buffer, overwriting any older pending entry (last write wins).
- A pending entry starts at the first IDLE edge after publication. For example, a write captured at E15 starts at E16.
- Hex-mode writes while busy also go to pending. They never bypass an in-flight conversion.

Other rules:
- led_ctrl is never high for two consecutive cycles from the same request.
- l0..l3 change only in a cycle where led_ctrl is being asserted.
- Reset mid-conversion aborts the conversion: digits return to 0 and the pending buffer clears.
- Arithmetic: the BCD field is 16 bits (4 nibbles). No digit ever exceeds 9 in decimal mode.

Optional Feature:
- Macro: LED_OVF_HEX_FALLBACK_EN.
- When defined: a decimal-mode write with wr_data > DEC_MAX is not converted. It is published as hex with hex-mode timing (latency 1, no CONV), and ovf <= 1.
- When undefined: the value saturates to 9999, is converted normally (latency 15), and ovf <= 1.

Test Plan:
- Reset, then hex write wr_data=16'h1A2F -> one cycle later led_ctrl=1, l3..l0 = 1,A,2,F, ovf=0, busy never high.
- Decimal write 16'd1234 -> busy high for 15 cycles; led_ctrl high 15 cycles after the write edge; l3..l0 = 1,2,3,4; ovf=0.
- Decimal write 16'd12345:
  - Without the macro: after 15 cycles, digits 9,9,9,9 and ovf=1.
  - With LED_OVF_HEX_FALLBACK_EN: after 1 cycle, digits 3,0,3,9 (16'h3039) and ovf=1.
- Decimal write 16'd42, then decimal writes 16'd7 at cycle +3 and 16'd88 at cycle +5:
  - First strobe shows 0,0,4,2.
  - 16'd7 is discarded.
  - The second conversion starts one edge after the first strobe; its strobe shows 0,0,8,8.
- Decimal write 16'd9999, then assert rst at cycle +6 for 2 cycles -> outputs 0, busy=0, no led_ctrl pulse; a subsequent hex write 16'h0005 shows 0,0,0,5 after 1 cycle.
- Decimal write 16'd0 -> after 15 cycles, digits 0,0,0,0 with a single-cycle led_ctrl; a write sampled exactly at E15 is started at E16.

Source files
------------

// File: rtl/led_bcd_feeder.sv
// LED value feeder: hex pass-through or sequential double-dabble BCD conversion,
// with a one-deep pending buffer. Optional macro: LED_OVF_HEX_FALLBACK_EN.
module led_bcd_feeder #(
  parameter int CONV_BITS = 14,
  parameter int DEC_MAX   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        dec_mode,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  l0,
  output logic [3:0]  l1,
  output logic [3:0]  l2,
  output logic [3:0]  l3,
  output logic        led_ctrl
);

  localparam int              SW        = 16 + CONV_BITS;
  localparam int              CW        = $clog2(CONV_BITS + 1);
  localparam logic [15:0]     DEC_MAX_W = 16'(DEC_MAX);
  localparam logic [CW-1:0]   LAST_CNT  = CW'(CONV_BITS);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sh_q, sh_d, sh_adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   digits_q, digits_d;
  logic          ovf_q, ovf_d;
  logic          conv_ovf_q, conv_ovf_d;
  logic          led_ctrl_q, led_ctrl_d;
  logic          busy_q, busy_d;
  logic          pend_v_q, pend_v_d;
  logic          pend_dec_q, pend_dec_d;
  logic [15:0]   pend_data_q, pend_data_d;

  logic          req_v, req_dec, req_big, req_hex;
  logic [15:0]   req_data, req_sat;

  // A fresh write always takes precedence over the pending entry.
  assign req_v    = wr_en | pend_v_q;
  assign req_dec  = wr_en ? dec_mode : pend_dec_q;
  assign req_data = wr_en ? wr_data : pend_data_q;
  assign req_big  = req_data > DEC_MAX_W;
  assign req_sat  = req_big ? DEC_MAX_W : req_data;
`ifdef LED_OVF_HEX_FALLBACK_EN
  assign req_hex  = ~req_dec | req_big;
`else
  assign req_hex  = ~req_dec;
`endif

  // Add-3 correction on each BCD nibble ahead of the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      localparam int LO = CONV_BITS + 4 * gi;
      assign sh_adj[LO+3:LO] = (sh_q[LO+3:LO] >= 4'd5) ? (sh_q[LO+3:LO] + 4'd3)
                                                        : sh_q[LO+3:LO];
    end
  endgenerate
  assign sh_adj[CONV_BITS-1:0] = sh_q[CONV_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      ovf_q       <= 1'b0;
      conv_ovf_q  <= 1'b0;
      led_ctrl_q  <= 1'b0;
      busy_q      <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_dec_q  <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      ovf_q       <= ovf_d;
      conv_ovf_q  <= conv_ovf_d;
      led_ctrl_q  <= led_ctrl_d;
      busy_q      <= busy_d;
      pend_v_q    <= pend_v_d;
      pend_dec_q  <= pend_dec_d;
      pend_data_q <= pend_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_v && !req_hex) state_d = S_CONV;
      S_CONV:  if (cnt_q == LAST_CNT) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    ovf_d       = ovf_q;
    conv_ovf_d  = conv_ovf_q;
    led_ctrl_d  = 1'b0;
    pend_v_d    = pend_v_q;
    pend_dec_d  = pend_dec_q;
    pend_data_d = pend_data_q;
    busy_d      = (state_d == S_CONV);
    case (state_q)
      S_IDLE: begin
        if (req_v) begin
          pend_v_d = 1'b0;
          if (req_hex) begin
            digits_d   = req_data;
            ovf_d      = req_dec & req_big;
            led_ctrl_d = 1'b1;
          end else begin
            sh_d       = SW'(req_sat);
            cnt_d      = '0;
            conv_ovf_d = req_big;
          end
        end
      end
      S_CONV: begin
        if (wr_en) begin
          pend_v_d    = 1'b1;
          pend_dec_d  = dec_mode;
          pend_data_d = wr_data;
        end
        if (cnt_q == LAST_CNT) begin
          digits_d   = sh_q[SW-1:CONV_BITS];
          ovf_d      = conv_ovf_q;
          led_ctrl_d = 1'b1;
        end else begin
          sh_d  = sh_adj << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign ovf      = ovf_q;
  assign led_ctrl = led_ctrl_q;
  assign l0       = digits_q[3:0];
  assign l1       = digits_q[7:4];
  assign l2       = digits_q[11:8];
  assign l3       = digits_q[15:12];

endmodule

// File: tb/tb_led_bcd_feeder.sv
// Directed bench for led_bcd_feeder: hex, decimal, saturation, pending buffer,
// reset abort and E15 write capture.
module tb_led_bcd_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        dec_mode = 1'b0;
  logic        busy, ovf, led_ctrl;
  logic [3:0]  l0, l1, l2, l3;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int c0 = 0;
  int cnt = 0;

  led_bcd_feeder dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .dec_mode(dec_mode),
    .busy(busy), .ovf(ovf), .l0(l0), .l1(l1), .l2(l2), .l3(l3), .led_ctrl(led_ctrl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[%0d] %s: observed %0h expected %0h", cyc, tag, obs, exp);
  endtask

  // Present a write that the next edge (E0) samples; returns after E0.
  task automatic write(input logic dm, input logic [15:0] d);
    wr_en = 1'b1; dec_mode = dm; wr_data = d;
    tick();
    wr_en = 1'b0;
    c0 = cyc;
  endtask

  // Advance until led_ctrl is seen, bounded.
  task automatic wait_strobe();
    for (int i = 0; i < 40 && !led_ctrl; i++) tick();
  endtask

  function automatic logic [15:0] digits();
    return {l3, l2, l1, l0};
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_digits", 32'(digits()), 32'h0);
    chk("rst_led_ctrl", 32'(led_ctrl), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b1;
    tick();

    // Hex pass-through
    write(1'b0, 16'h1A2F);
    chk("hex_strobe", 32'(led_ctrl), 32'h1);
    chk("hex_digits", 32'(digits()), 32'h1A2F);
    chk("hex_ovf", 32'(ovf), 32'h0);
    chk("hex_busy", 32'(busy), 32'h0);
    tick();
    chk("hex_strobe_single", 32'(led_ctrl), 32'h0);

    // Decimal 1234: busy cycles and latency
    write(1'b1, 16'd1234);
    cnt = 0;
    for (int i = 0; i < 40 && !led_ctrl; i++) begin
      if (busy) cnt++;
      tick();
    end
    chk("dec1234_busy_cycles", 32'(cnt), 32'd15);
    chk("dec1234_latency", 32'(cyc - c0), 32'd15);
    chk("dec1234_digits", 32'(digits()), 32'h1234);
    chk("dec1234_ovf", 32'(ovf), 32'h0);
    tick();
    chk("dec1234_strobe_single", 32'(led_ctrl), 32'h0);

    // Out-of-range decimal value
    write(1'b1, 16'd12345);
    wait_strobe();
`ifdef LED_OVF_HEX_FALLBACK_EN
    chk("dec12345_latency", 32'(cyc - c0), 32'd0);
    chk("dec12345_digits", 32'(digits()), 32'h3039);
`else
    chk("dec12345_latency", 32'(cyc - c0), 32'd15);
    chk("dec12345_digits", 32'(digits()), 32'h9999);
`endif
    chk("dec12345_ovf", 32'(ovf), 32'h1);
    tick();

    // Pending buffer: 7 is overwritten by 88
    write(1'b1, 16'd42);
    tick(); tick();
    wr_en = 1'b1; dec_mode = 1'b1; wr_data = 16'd7;
    tick();
    wr_en = 1'b0;
    tick();
    wr_en = 1'b1; dec_mode = 1'b1; wr_data = 16'd88;
    tick();
    wr_en = 1'b0;
    wait_strobe();
    chk("pend_first_latency", 32'(cyc - c0), 32'd15);
    chk("pend_first_digits", 32'(digits()), 32'h0042);
    chk("pend_first_ovf", 32'(ovf), 32'h0);
    tick();
    chk("pend_second_busy", 32'(busy), 32'h1);
    chk("pend_second_hold", 32'(digits()), 32'h0042);
    wait_strobe();
    chk("pend_second_latency", 32'(cyc - c0), 32'd31);
    chk("pend_second_digits", 32'(digits()), 32'h0088);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (led_ctrl) cnt++;
    end
    chk("pend_no_third_strobe", 32'(cnt), 32'd0);

    // Reset mid-conversion
    write(1'b1, 16'd9999);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_busy_before", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_digits", 32'(digits()), 32'h0);
    tick(); tick();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (led_ctrl || busy) cnt++;
    end
    chk("abort_no_activity", 32'(cnt), 32'd0);
    write(1'b0, 16'h0005);
    chk("post_abort_strobe", 32'(led_ctrl), 32'h1);
    chk("post_abort_digits", 32'(digits()), 32'h0005);
    tick();

    // Decimal 0 with a write captured exactly at E15
    write(1'b1, 16'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("zero_busy_e14", 32'(busy), 32'h1);
    wr_en = 1'b1; dec_mode = 1'b1; wr_data = 16'd5;
    tick();
    wr_en = 1'b0;
    chk("zero_strobe", 32'(led_ctrl), 32'h1);
    chk("zero_digits", 32'(digits()), 32'h0000);
    tick();
    chk("zero_strobe_single", 32'(led_ctrl), 32'h0);
    chk("e15_write_started", 32'(busy), 32'h1);
    wait_strobe();
    chk("e15_write_latency", 32'(cyc - c0), 32'd31);
    chk("e15_write_digits", 32'(digits()), 32'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
